// File: rtl/burst_memory.sv
// -----------------------------------------------------------------------------
// burst_memory
//
// Byte-addressable, single-port synchronous memory with burst support. It
// models the instruction/data memory behind the fetch and load/store paths.
// A request is accepted in IDLE when enable is high. The access then runs for
// 1, 4, 8 or 16 words. The burst length, direction and start address are
// captured at acceptance. Each following beat steps by one word and wraps at
// the top of memory.
//
// Ports
//   clock        in   rising-edge clock
//   reset_n      in   asynchronous active-low reset, synchronous release
//   enable       in   request strobe; ignored while a burst is running
//   rw           in   1 = write, 0 = read
//   address      in   byte start address (aligned down to a word, upper bits
//                     beyond the memory size ignored)
//   access_size  in   00 = 1 word, 01 = 4, 10 = 8, 11 = 16 words
//   data_in      in   write data for the current beat
//   busy         out  multi-word burst in progress
//   data_out     out  registered read data (holds when data_valid is low)
//   data_valid   out  data_out carries a read beat this cycle
// -----------------------------------------------------------------------------
module burst_memory #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_BYTES = 1048576
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [1:0]            access_size,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid
);

    localparam int BYTES       = DATA_WIDTH / 8;
    localparam int LOG2_BYTES  = $clog2(BYTES);
    localparam int DEPTH_WORDS = DEPTH_BYTES / BYTES;
    localparam int WORD_AW     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_e;

    // Each entry is one whole word. The byte at the lowest address sits in
    // the most significant byte lane, so storing data_in unchanged gives
    // big-endian byte order for free.
    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    state_e               state_q, state_d;
    logic [WORD_AW-1:0]   addr_q, addr_d;          // word index of the next beat
    logic [3:0]           beats_left_q, beats_left_d;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                 data_valid_q;

    logic                 accept;
    logic [WORD_AW-1:0]   start_word;
    logic [3:0]           burst_len_m1;
    logic [WORD_AW-1:0]   beat_word;
    logic                 rd_en;
    logic                 wr_en;

    // Dropping the low byte-offset bits aligns misaligned starts down. Slicing
    // only WORD_AW bits drops everything at or above log2(DEPTH_BYTES).
    assign start_word = address[LOG2_BYTES +: WORD_AW];

    // Only the sliced bits of address matter; the rest are intentionally dropped.
    logic unused_address;
    assign unused_address = ^address;

    assign accept = (state_q == ST_IDLE) && enable;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        burst_len_m1 = 4'd0;
        unique case (access_size)
            2'b00: burst_len_m1 = 4'd0;
            2'b01: burst_len_m1 = 4'd3;
            2'b10: burst_len_m1 = 4'd7;
            2'b11: burst_len_m1 = 4'd15;
            default: burst_len_m1 = 4'd0;
        endcase
    end

    // Beat 0 uses the live request address. Later beats use the captured counter.
    assign beat_word = accept ? start_word : addr_q;
    assign rd_en     = (accept && !rw) || (state_q == ST_READ);
    assign wr_en     = (accept &&  rw) || (state_q == ST_WRITE);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                // A single-word access completes in its accepting cycle,
                // so only longer bursts leave IDLE.
                if (accept && (burst_len_m1 != 4'd0)) begin
                    state_d = rw ? ST_WRITE : ST_READ;
                end
            end
            ST_READ, ST_WRITE: begin
                if (beats_left_q == 4'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs and datapath next state
    // ------------------------------------------------------------------------
    always_comb begin
        busy         = (state_q != ST_IDLE);
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        if (accept) begin
            addr_d       = start_word + WORD_AW'(1);
            beats_left_d = burst_len_m1;
        end else if (state_q != ST_IDLE) begin
            // The natural WORD_AW-bit rollover wraps the burst to address 0.
            addr_d       = addr_q + WORD_AW'(1);
            beats_left_d = beats_left_q - 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_q       <= '0;
            beats_left_q <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            data_valid_q <= rd_en;
            if (rd_en) begin
                data_out_q <= mem[beat_word];
            end
        end
    end

    // NOTE: the storage array has no reset. Clearing a RAM is neither possible
    // in one cycle nor wanted, and contents survive a reset.
    // Reset stops a burst by forcing state_q to IDLE, so no more beats are written.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[beat_word] <= data_in;
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;

endmodule
